// File: rtl/store_buffer_if.sv
// Store buffer port bundle: dispatch, LSU fill, load bypass, ROB commit, memory drain.
// mem_wr handshake: request is held stable while mem_wr_v_o is high; a write transfers on mem_wr_v_o & mem_wr_ready_i.
interface store_buffer_if #(
    parameter int WORD_SIZE_P = 16,
    parameter int SB_ENTRY    = 8
);
    localparam int IDX_W        = $clog2(SB_ENTRY);
    localparam int CDB_SB_WIDTH = IDX_W + 2 * WORD_SIZE_P;

    logic                    alloc_v_i;
    logic [IDX_W-1:0]        sb_tail_o;
    logic                    sb_full_o;
    logic                    sb_empty_o;
    logic                    lsu_sb_v_i;
    logic [CDB_SB_WIDTH-1:0] lsu_sb_i;
    logic [WORD_SIZE_P-1:0]  exe_ld_bypass_addr_i;
    logic [IDX_W-1:0]        exe_ld_bypass_sb_num_i;
    logic                    sb_ld_bypass_valid_o;
    logic [WORD_SIZE_P-1:0]  sb_ld_bypass_value_o;
    logic                    commit_st_v_i;
    logic                    mem_wr_v_o;
    logic [WORD_SIZE_P-1:0]  mem_wr_addr_o;
    logic [WORD_SIZE_P-1:0]  mem_wr_data_o;
    logic                    mem_wr_ready_i;
    logic                    mispredict_i;

    modport slave (
        input  alloc_v_i, lsu_sb_v_i, lsu_sb_i, exe_ld_bypass_addr_i,
               exe_ld_bypass_sb_num_i, commit_st_v_i, mem_wr_ready_i, mispredict_i,
        output sb_tail_o, sb_full_o, sb_empty_o, sb_ld_bypass_valid_o,
               sb_ld_bypass_value_o, mem_wr_v_o, mem_wr_addr_o, mem_wr_data_o
    );

    modport master (
        output alloc_v_i, lsu_sb_v_i, lsu_sb_i, exe_ld_bypass_addr_i,
               exe_ld_bypass_sb_num_i, commit_st_v_i, mem_wr_ready_i, mispredict_i,
        input  sb_tail_o, sb_full_o, sb_empty_o, sb_ld_bypass_valid_o,
               sb_ld_bypass_value_o, mem_wr_v_o, mem_wr_addr_o, mem_wr_data_o
    );
endinterface

// File: rtl/store_buffer.sv
// Circular store buffer with in-order commit/drain and mispredict flush.
// Define PJ_SB_BYPASS_EN to build the store-to-load bypass search; otherwise bypass outputs are tied to 0.
module store_buffer #(
    parameter int WORD_SIZE_P = 16,
    parameter int SB_ENTRY    = 8
) (
    input logic           clk_i,
    input logic           reset_n_i,
    store_buffer_if.slave sb
);
    localparam int IDX_W = $clog2(SB_ENTRY);
    localparam int W     = WORD_SIZE_P;

    typedef logic [IDX_W:0]   ptr_t;
    typedef logic [IDX_W-1:0] idx_t;

    logic [SB_ENTRY-1:0] occ_q, occ_d, fil_q, fil_d, com_q, com_d;
    logic [W-1:0]        addr_q [SB_ENTRY];
    logic [W-1:0]        addr_d [SB_ENTRY];
    logic [W-1:0]        data_q [SB_ENTRY];
    logic [W-1:0]        data_d [SB_ENTRY];
    ptr_t                head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;

    idx_t         head_idx, cmt_idx, tail_idx, fill_idx;
    logic [W-1:0] fill_addr, fill_data;
    logic         full, empty;
    logic         alloc_fire, fill_fire, commit_fire, drain_v, drain_fire;

    assign head_idx = head_q[IDX_W-1:0];
    assign cmt_idx  = cmt_q[IDX_W-1:0];
    assign tail_idx = tail_q[IDX_W-1:0];
    assign {fill_idx, fill_addr, fill_data} = sb.lsu_sb_i;

    assign full  = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
    assign empty = (head_q == tail_q);

    // Fills to entries that were flushed (or already committed) are dropped.
    assign alloc_fire  = sb.alloc_v_i & ~full & ~sb.mispredict_i;
    assign fill_fire   = sb.lsu_sb_v_i & occ_q[fill_idx] & ~com_q[fill_idx];
    assign commit_fire = sb.commit_st_v_i & occ_q[cmt_idx];
    assign drain_v     = occ_q[head_idx] & com_q[head_idx];
    assign drain_fire  = drain_v & sb.mem_wr_ready_i;

    always_comb begin
        occ_d  = occ_q;
        fil_d  = fil_q;
        com_d  = com_q;
        addr_d = addr_q;
        data_d = data_q;
        head_d = head_q;
        cmt_d  = cmt_q;
        tail_d = tail_q;

        if (fill_fire) begin
            addr_d[fill_idx] = fill_addr;
            data_d[fill_idx] = fill_data;
            fil_d[fill_idx]  = 1'b1;
        end
        if (commit_fire) begin
            com_d[cmt_idx] = 1'b1;
            cmt_d          = cmt_q + ptr_t'(1);
        end
        if (drain_fire) begin
            occ_d[head_idx] = 1'b0;
            fil_d[head_idx] = 1'b0;
            com_d[head_idx] = 1'b0;
            head_d          = head_q + ptr_t'(1);
        end
        if (alloc_fire) begin
            occ_d[tail_idx] = 1'b1;
            fil_d[tail_idx] = 1'b0;
            com_d[tail_idx] = 1'b0;
            tail_d          = tail_q + ptr_t'(1);
        end
        // Flush sees this cycle's commit, so the retiring store survives.
        if (sb.mispredict_i) begin
            tail_d = cmt_d;
            for (int i = 0; i < SB_ENTRY; i++) begin
                if (!com_d[i]) begin
                    occ_d[i] = 1'b0;
                    fil_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            occ_q  <= '0;
            fil_q  <= '0;
            com_q  <= '0;
            head_q <= '0;
            cmt_q  <= '0;
            tail_q <= '0;
            for (int i = 0; i < SB_ENTRY; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            occ_q  <= occ_d;
            fil_q  <= fil_d;
            com_q  <= com_d;
            head_q <= head_d;
            cmt_q  <= cmt_d;
            tail_q <= tail_d;
            for (int i = 0; i < SB_ENTRY; i++) begin
                addr_q[i] <= addr_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    assign sb.sb_tail_o     = tail_idx;
    assign sb.sb_full_o     = full;
    assign sb.sb_empty_o    = empty;
    assign sb.mem_wr_v_o    = drain_v;
    assign sb.mem_wr_addr_o = addr_q[head_idx];
    assign sb.mem_wr_data_o = data_q[head_idx];

`ifdef PJ_SB_BYPASS_EN
    logic         byp_v;
    logic [W-1:0] byp_val;
    idx_t         n_older, scan_idx;

    // Scan oldest to youngest so the last hit is the youngest older store.
    always_comb begin
        byp_v    = 1'b0;
        byp_val  = '0;
        n_older  = sb.exe_ld_bypass_sb_num_i - head_idx;
        scan_idx = '0;
        for (int k = 0; k < SB_ENTRY; k++) begin
            scan_idx = head_idx + idx_t'(k);
            if ((idx_t'(k) < n_older) && fil_q[scan_idx] &&
                (addr_q[scan_idx] == sb.exe_ld_bypass_addr_i)) begin
                byp_v   = 1'b1;
                byp_val = data_q[scan_idx];
            end
        end
    end

    assign sb.sb_ld_bypass_valid_o = byp_v;
    assign sb.sb_ld_bypass_value_o = byp_val;
`else
    logic unused_bypass;
    assign unused_bypass = ^{sb.exe_ld_bypass_addr_i, sb.exe_ld_bypass_sb_num_i};

    assign sb.sb_ld_bypass_valid_o = 1'b0;
    assign sb.sb_ld_bypass_value_o = '0;
`endif
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: table-driven bypass lookups plus hand-written allocate/commit/drain/flush/wrap sequences.
module tb_store_buffer;
    localparam int W = 16;
    localparam int N = 8;
`ifdef PJ_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    logic [2*W-1:0] exp_q[$];

    store_buffer_if #(.WORD_SIZE_P(W), .SB_ENTRY(N)) sbif ();

    store_buffer #(.WORD_SIZE_P(W), .SB_ENTRY(N)) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .sb        (sbif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   num;
        logic [W-1:0] addr;
        logic         exp_v;
        logic [W-1:0] exp_val;
    } vec_t;
    vec_t vecs [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Memory-side scoreboard: every accepted write must match the next expected {addr,data}.
    always @(negedge clk) begin
        if (rst_n && sbif.mem_wr_v_o && sbif.mem_wr_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {sbif.mem_wr_addr_o, sbif.mem_wr_data_o}, 32'hxxxx_xxxx);
            end else begin
                chk("mem_write", {sbif.mem_wr_addr_o, sbif.mem_wr_data_o}, exp_q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst_n                       = 1'b0;
        sbif.alloc_v_i              = 1'b0;
        sbif.lsu_sb_v_i             = 1'b0;
        sbif.lsu_sb_i               = '0;
        sbif.exe_ld_bypass_addr_i   = '0;
        sbif.exe_ld_bypass_sb_num_i = '0;
        sbif.commit_st_v_i          = 1'b0;
        sbif.mem_wr_ready_i         = 1'b0;
        sbif.mispredict_i           = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic do_alloc(input int n);
        sbif.alloc_v_i = 1'b1;
        repeat (n) cyc();
        sbif.alloc_v_i = 1'b0;
    endtask

    task automatic do_fill(input logic [2:0] idx, input logic [W-1:0] a, input logic [W-1:0] d);
        sbif.lsu_sb_v_i = 1'b1;
        sbif.lsu_sb_i   = {idx, a, d};
        cyc();
        sbif.lsu_sb_v_i = 1'b0;
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            sbif.exe_ld_bypass_sb_num_i = vecs[i].num;
            sbif.exe_ld_bypass_addr_i   = vecs[i].addr;
            settle();
            chk($sformatf("byp_valid[%0d]", i), 32'(sbif.sb_ld_bypass_valid_o), BYP ? 32'(vecs[i].exp_v) : 32'd0);
            chk($sformatf("byp_value[%0d]", i), 32'(sbif.sb_ld_bypass_value_o), BYP ? 32'(vecs[i].exp_val) : 32'd0);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        // Scenario: two stores to 0x0040 in entries 0,1
        vecs[0]  = '{3'd2, 16'h0040, 1'b1, 16'hBBBB};
        vecs[1]  = '{3'd1, 16'h0040, 1'b1, 16'hAAAA};
        vecs[2]  = '{3'd0, 16'h0040, 1'b0, 16'h0000};
        vecs[3]  = '{3'd2, 16'h0041, 1'b0, 16'h0000};
        // After flush: dropped fill to entry 2 must not be found
        vecs[4]  = '{3'd3, 16'h0077, 1'b0, 16'h0000};
        // Wrap: head=6, entries 6,7,0,1; 6={10,1111} 7={10,1234} 1={10,9999}, 0 unfilled (stale addr 0x0100)
        vecs[5]  = '{3'd1, 16'h0010, 1'b1, 16'h1234};
        vecs[6]  = '{3'd0, 16'h0010, 1'b1, 16'h1234};
        vecs[7]  = '{3'd7, 16'h0010, 1'b1, 16'h1111};
        vecs[8]  = '{3'd6, 16'h0010, 1'b0, 16'h0000};
        vecs[9]  = '{3'd2, 16'h0010, 1'b1, 16'h9999};
        vecs[10] = '{3'd1, 16'h0011, 1'b0, 16'h0000};
        vecs[11] = '{3'd1, 16'h0100, 1'b0, 16'h0000};
        vecs[12] = '{3'd6, 16'h0100, 1'b0, 16'h0000};

        do_reset();
        chk("rst_empty", 32'(sbif.sb_empty_o), 32'd1);
        chk("rst_full", 32'(sbif.sb_full_o), 32'd0);
        chk("rst_tail", 32'(sbif.sb_tail_o), 32'd0);
        chk("rst_wr_v", 32'(sbif.mem_wr_v_o), 32'd0);
        chk("rst_wr_addr", 32'(sbif.mem_wr_addr_o), 32'd0);
        chk("rst_wr_data", 32'(sbif.mem_wr_data_o), 32'd0);
        chk("rst_byp_v", 32'(sbif.sb_ld_bypass_valid_o), 32'd0);
        chk("rst_byp_val", 32'(sbif.sb_ld_bypass_value_o), 32'd0);

        // Fill to capacity, then one ignored allocation
        for (int i = 0; i < N; i++) begin
            do_alloc(1);
            chk($sformatf("alloc_tail[%0d]", i), 32'(sbif.sb_tail_o), 32'((i + 1) % N));
        end
        chk("full_after_8", 32'(sbif.sb_full_o), 32'd1);
        chk("not_empty_after_8", 32'(sbif.sb_empty_o), 32'd0);
        do_alloc(1);
        chk("ninth_tail", 32'(sbif.sb_tail_o), 32'd0);
        chk("ninth_full", 32'(sbif.sb_full_o), 32'd1);
        sbif.mispredict_i = 1'b1;
        cyc();
        sbif.mispredict_i = 1'b0;
        chk("flush_all_empty", 32'(sbif.sb_empty_o), 32'd1);
        chk("flush_all_full", 32'(sbif.sb_full_o), 32'd0);

        // Bypass youngest-older selection
        do_alloc(2);
        do_fill(3'd0, 16'h0040, 16'hAAAA);
        do_fill(3'd1, 16'h0040, 16'hBBBB);
        run_vecs(0, 3);

        // Commit two with memory stalled, then drain back to back
        exp_q.push_back({16'h0040, 16'hAAAA});
        exp_q.push_back({16'h0040, 16'hBBBB});
        sbif.commit_st_v_i = 1'b1;
        repeat (2) cyc();
        sbif.commit_st_v_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk($sformatf("hold_v[%0d]", i), 32'(sbif.mem_wr_v_o), 32'd1);
            chk($sformatf("hold_addr[%0d]", i), 32'(sbif.mem_wr_addr_o), 32'h0040);
            chk($sformatf("hold_data[%0d]", i), 32'(sbif.mem_wr_data_o), 32'hAAAA);
            cyc();
        end
        sbif.mem_wr_ready_i = 1'b1;
        repeat (2) cyc();
        sbif.mem_wr_ready_i = 1'b0;
        chk("drain_empty", 32'(sbif.sb_empty_o), 32'd1);
        chk("drain_v_low", 32'(sbif.mem_wr_v_o), 32'd0);
        chk("drain_q_used", 32'(exp_q.size()), 32'd0);

        // Mispredict in the same cycle as a commit keeps the committed store
        do_reset();
        do_alloc(4);
        do_fill(3'd0, 16'h0050, 16'h5555);
        sbif.commit_st_v_i = 1'b1;
        sbif.mispredict_i  = 1'b1;
        cyc();
        sbif.commit_st_v_i = 1'b0;
        sbif.mispredict_i  = 1'b0;
        chk("mp_tail", 32'(sbif.sb_tail_o), 32'd1);
        chk("mp_wr_v", 32'(sbif.mem_wr_v_o), 32'd1);
        chk("mp_wr_addr", 32'(sbif.mem_wr_addr_o), 32'h0050);
        do_fill(3'd2, 16'h0077, 16'h7777);
        run_vecs(4, 4);
        chk("mp_tail_after_fill", 32'(sbif.sb_tail_o), 32'd1);
        exp_q.push_back({16'h0050, 16'h5555});
        sbif.mem_wr_ready_i = 1'b1;
        cyc();
        sbif.mem_wr_ready_i = 1'b0;
        chk("mp_drain_empty", 32'(sbif.sb_empty_o), 32'd1);
        chk("mp_drain_v", 32'(sbif.mem_wr_v_o), 32'd0);

        // Reset asserted while a write is pending drops it immediately
        do_alloc(1);
        do_fill(3'd1, 16'h0060, 16'h6666);
        sbif.commit_st_v_i = 1'b1;
        cyc();
        sbif.commit_st_v_i = 1'b0;
        settle();
        chk("pre_rst_wr_v", 32'(sbif.mem_wr_v_o), 32'd1);
        rst_n = 1'b0;
        settle();
        chk("mid_rst_wr_v", 32'(sbif.mem_wr_v_o), 32'd0);
        chk("mid_rst_empty", 32'(sbif.sb_empty_o), 32'd1);
        chk("mid_rst_data", 32'(sbif.mem_wr_data_o), 32'd0);
        cyc();
        do_reset();

        // Move head to 6 through six committed, drained stores
        do_alloc(6);
        for (int i = 0; i < 6; i++) begin
            do_fill(3'(i), 16'(16'h0100 + i), 16'(16'h2000 + i));
            exp_q.push_back({16'(16'h0100 + i), 16'(16'h2000 + i)});
        end
        sbif.mem_wr_ready_i = 1'b1;
        sbif.commit_st_v_i  = 1'b1;
        repeat (6) cyc();
        sbif.commit_st_v_i = 1'b0;
        cyc();
        sbif.mem_wr_ready_i = 1'b0;
        chk("pre_wrap_empty", 32'(sbif.sb_empty_o), 32'd1);
        chk("pre_wrap_tail", 32'(sbif.sb_tail_o), 32'd6);
        chk("pre_wrap_q_used", 32'(exp_q.size()), 32'd0);

        // Wrap around the end of the array
        do_alloc(4);
        chk("wrap_tail", 32'(sbif.sb_tail_o), 32'd2);
        chk("wrap_full", 32'(sbif.sb_full_o), 32'd0);
        do_fill(3'd6, 16'h0010, 16'h1111);
        do_fill(3'd7, 16'h0010, 16'h1234);
        do_fill(3'd1, 16'h0010, 16'h9999);
        run_vecs(5, 12);
        chk("wrap_no_write", 32'(sbif.mem_wr_v_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/store_buffer.md
# store_buffer

Circular store buffer between the load/store unit and data memory. Stores reserve an entry at dispatch. The LSU later fills each entry with address and data. The ROB marks stores committed in program order, and committed stores drain to memory in order. Loads in the LSU's second stage search the buffer for the youngest older store to the same address and bypass its data. Uncommitted entries are flushed on a branch mispredict.

## Interface
- WORD_SIZE_P, 16, address/data width
- SB_ENTRY, 8, number of entries (power of two, ≥2)
- clk_i  in  1  clock
- reset_n_i  in  1  reset; asynchronous, active-low
- alloc_v_i  in  1  dispatch reserves one entry at tail
- sb_tail_o  out  $clog2(SB_ENTRY)  current tail index; this is the sb_dest given to the dispatching store or load
- sb_full_o  out  1  all entries occupied; dispatch must stall both stores and loads
- sb_empty_o  out  1  no entries occupied
- lsu_sb_v_i  in  1  LSU store writeback valid
- lsu_sb_i  in  CDB_SB_WIDTH  CDB_sb_t {sb_dest, address, result}
- exe_ld_bypass_addr_i  in  WORD_SIZE_P  load address
- exe_ld_bypass_sb_num_i  in  $clog2(SB_ENTRY)  load's sb_dest; tail index at the load's dispatch
- sb_ld_bypass_valid_o  out  1  a matching older store was found
- sb_ld_bypass_value_o  out  WORD_SIZE_P  data of that store
- commit_st_v_i  in  1  ROB retires the oldest uncommitted store
- mem_wr_v_o  out  1  store write request
- mem_wr_addr_o  out  WORD_SIZE_P  write address
- mem_wr_data_o  out  WORD_SIZE_P  write data
- mem_wr_ready_i  in  1  memory accepts the request this cycle
- mispredict_i  in  1  flush all uncommitted entries

## Operation
- State per entry: occupied, filled, committed, addr, data.
- Pointers: head (oldest), cmt (oldest uncommitted), tail (next free). Each pointer carries an extra wrap bit.
  - Fullness: full = index bits equal and wrap bits differ.
  - Emptiness: empty = head == tail, including the wrap bit.
- Allocate: when alloc_v_i is high, the buffer is not full and mispredict_i is low:
  - set entry[tail] occupied, with filled and committed cleared;
  - increment tail.
  - alloc_v_i while full is ignored and is a protocol error.
- Fill: when lsu_sb_v_i is high and entry[sb_dest] is occupied and uncommitted, write addr and data and set filled. A write to a non-occupied entry is dropped; this covers a store flushed in flight.
- Commit: when commit_st_v_i is high, set entry[cmt] committed and increment cmt. The ROB guarantees that this entry is filled.
- Drain: mem_wr_v_o = entry[head] occupied & committed.
  - The address and data outputs come combinationally from entry[head].
  - On mem_wr_v_o & mem_wr_ready_i, clear occupied and increment head.
  - Drains are back-to-back, one per cycle.
- Mispredict: tail ← cmt and all uncommitted entries are cleared. A commit in the same cycle applies first, so tail ← cmt+1.
- Bypass (combinational, from registered state only):
  - Let n = (sb_num − head) mod SB_ENTRY. The older entries are indices sb_num−1 down to head, n entries in total.
  - Choose the youngest of these that is filled and whose addr equals exe_ld_bypass_addr_i. On a hit, valid = 1 and value = its data; otherwise valid = 0 and value = 0.
  - n = 0 means there are no older stores.
  - Unfilled older entries are skipped.
  - Index arithmetic is mod SB_ENTRY.
- Simultaneous events: allocate, fill, commit and drain may all occur in one cycle. Each acts on distinct state, and pointers update independently.

## Timing
- Reset (async assert, synchronous deassert use):
  - all pointers = 0 and all entry state = 0;
  - sb_full_o = 0, sb_empty_o = 1, sb_tail_o = 0;
  - mem_wr_v_o = 0, mem_wr_addr_o = 0, mem_wr_data_o = 0;
  - sb_ld_bypass_valid_o = 0, sb_ld_bypass_value_o = 0.
- A reset asserted mid-drain drops the request immediately.
- Allocate/fill/commit at edge t become visible on the outputs after edge t.
- Bypass latency is 0 cycles from the lookup inputs. A fill at edge t is visible to lookups from cycle t+1.
- Drain: a commit at edge t gives mem_wr_v_o in cycle t+1. mem_wr_v_o stays high until ready.

## Configuration
- PJ_SB_BYPASS_EN defined: the bypass search is as specified above.
- PJ_SB_BYPASS_EN undefined: sb_ld_bypass_valid_o = 0 and sb_ld_bypass_value_o = 0 always, and no comparators are built.

## Test plan
- Reset → sb_empty_o = 1, sb_tail_o = 0, mem_wr_v_o = 0. Then 8 allocations → sb_full_o = 1 and sb_tail_o = 0. A ninth alloc_v_i leaves the state unchanged.
- Allocate 2 stores and fill entry0 {0x0040, 0xAAAA} and entry1 {0x0040, 0xBBBB}. A load with sb_num = 2 and addr 0x0040 → valid = 1, value 0xBBBB. With sb_num = 1 → 0xAAAA. With sb_num = 0 → valid = 0.
- Commit 2 stores with mem_wr_ready_i = 0 for 3 cycles → mem_wr_v_o holds with addr 0x0040 and data 0xAAAA. Then ready = 1 for 2 cycles → two writes, sb_empty_o = 1.
- Allocate 4 stores and commit 1. Assert mispredict_i → sb_tail_o = 1. A subsequent LSU fill to entry 2 is dropped.
- Wrap: with head = 6, allocate 4 stores (indices 6, 7, 0, 1) and fill index 7 with addr 0x0010 and data 0x1234. A load with sb_num = 1 and addr 0x0010 → valid = 1, value 0x1234.
- With PJ_SB_BYPASS_EN undefined, repeat the second scenario → valid = 0 always.
